// File: rtl/multiplier_eval_pkg.sv
// Shared types and width helpers for the exhaustive multiplier evaluator.
package multiplier_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One extra bit so the count can reach 2^(2w) when every pair fails.
  function automatic int err_w(input int w);
    return 2*w + 1;
  endfunction

  // Worst case: every pair contributes 2w differing bits.
  function automatic int ham_w(input int w);
    return 2*w + $clog2(2*w) + 1;
  endfunction

  function automatic int pop_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/eval_popcount.sv
// Combinational population count; used only by the Hamming-sum option.
module eval_popcount
  import multiplier_eval_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]         x,
  output logic [pop_w(W)-1:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++)
      cnt = cnt + pop_w(W)'(x[i]);
  end

endmodule

// File: rtl/multiplier_evaluator.sv
// Exhaustive sweep checker for a WIDTH x WIDTH combinational multiplier.
// Optional MULT_EVAL_HAMMING_EN adds ham_sum, the total bit-error count.
module multiplier_evaluator
  import multiplier_eval_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [WIDTH-1:0]          A,
  output logic [WIDTH-1:0]          B,
  input  logic [2*WIDTH-1:0]        P,
  output logic                      busy,
  output logic                      done,
  output logic [err_w(WIDTH)-1:0]   err_count,
  output logic                      pass,
  output logic [WIDTH-1:0]          fail_a,
`ifdef MULT_EVAL_HAMMING_EN
  output logic [ham_w(WIDTH)-1:0]   ham_sum,
`endif
  output logic [WIDTH-1:0]          fail_b
);

  localparam int PW = 2*WIDTH;
  localparam int EW = err_w(WIDTH);

  state_t          state;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   prod;
  logic            seen;
  logic            mismatch;

  // Operands come straight from the index register, so P is checked in
  // the same cycle the operands are presented.
  assign A        = idx[WIDTH-1:0];
  assign B        = idx[PW-1:WIDTH];
  assign prod     = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign mismatch = (P != prod);
  assign busy     = (state == SWEEP);
  assign done     = (state == DONE);
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      seen      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SWEEP;
            idx       <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            seen      <= 1'b0;
          end
        end
        SWEEP: begin
          if (mismatch) begin
            err_count <= err_count + EW'(1);
            if (!seen) begin
              seen   <= 1'b1;
              fail_a <= A;
              fail_b <= B;
            end
          end
          // Stop on the last pair without wrapping so A/B hold all-ones.
          if (&idx) state <= DONE;
          else      idx   <= idx + PW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_EVAL_HAMMING_EN
  localparam int HW = ham_w(WIDTH);
  logic [pop_w(PW)-1:0] pc;

  eval_popcount #(.W(PW)) u_pop (
    .x   (P ^ prod),
    .cnt (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ham_sum <= '0;
    else if (state != SWEEP && start)
      ham_sum <= '0;
    else if (state == SWEEP)
      ham_sum <= ham_sum + HW'(pc);
  end
`endif

endmodule

// File: tb/tb_multiplier_evaluator.sv
// Randomized bench for multiplier_evaluator (WIDTH=2) with a pair-by-pair model.
module tb_multiplier_evaluator;

  localparam int W  = 2;
  localparam int NP = 1 << (2*W);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   A, B, fail_a, fail_b;
  logic [2*W-1:0] P;
  logic           busy, done, pass;
  logic [2*W:0]   err_count;
`ifdef MULT_EVAL_HAMMING_EN
  logic [2*W+$clog2(2*W):0] ham_sum;
`endif

  // 0 correct, 1 tied to zero, 2 off-by-one at A=3,B=2, 3 random xor mask
  int             mode;
  logic [2*W-1:0] mask [NP];

  int n_tests = 0;
  int n_fail  = 0;

  multiplier_evaluator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .P         (P),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .pass      (pass),
    .fail_a    (fail_a),
`ifdef MULT_EVAL_HAMMING_EN
    .ham_sum   (ham_sum),
`endif
    .fail_b    (fail_b)
  );

  always #5 clk = ~clk;

  // Behaviour of the multiplier under test for each mode.
  function automatic int mult_out(input int a, input int b);
    int p;
    p = (a * b) % NP;
    case (mode)
      1: p = 0;
      2: if (a == 3 && b == 2) p = (p + 1) % NP;
      3: p = p ^ int'(mask[b*(1<<W) + a]);
      default: ;
    endcase
    return p;
  endfunction

  always_comb P = (2*W)'(mult_out(int'(A), int'(B)));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".A"}, A, 0);
    chk({tag, ".B"}, B, 0);
    chk({tag, ".err"}, err_count, 0);
    chk({tag, ".fail_a"}, fail_a, 0);
    chk({tag, ".fail_b"}, fail_b, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
`ifdef MULT_EVAL_HAMMING_EN
    chk({tag, ".ham"}, ham_sum, 0);
`endif
  endtask

  // Walk every pair in sweep order and compare with the true product.
  task automatic check_results(input string tag);
    int errs, fa, fb, ham, p, g;
    bit first;
    errs = 0; fa = 0; fb = 0; ham = 0; first = 1'b1;
    for (int b = 0; b < (1<<W); b++)
      for (int a = 0; a < (1<<W); a++) begin
        p = mult_out(a, b);
        g = a * b;
        if (p != g) begin
          errs++;
          if (first) begin fa = a; fb = b; first = 1'b0; end
        end
        ham += $countones(p ^ g);
      end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".err"}, err_count, errs);
    chk({tag, ".fail_a"}, fail_a, fa);
    chk({tag, ".fail_b"}, fail_b, fb);
    chk({tag, ".pass"}, pass, errs == 0);
    chk({tag, ".holdA"}, A, (1<<W) - 1);
    chk({tag, ".holdB"}, B, (1<<W) - 1);
`ifdef MULT_EVAL_HAMMING_EN
    chk({tag, ".ham"}, ham_sum, ham);
`endif
  endtask

  // Pulse start, count busy cycles; optionally re-pulse start or reset mid-sweep.
  task automatic run_sweep(input string tag, input int restart_at, input int rst_at,
                           input int exp_cycles);
    int ncyc;
    bit finished;
    ncyc = 0; finished = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (!busy) begin finished = 1'b1; break; end
      ncyc++;
      start = (ncyc == restart_at);
      if (ncyc == rst_at) begin
        rst = 1'b1;
        #1;
        chk_zero({tag, ".rst"});
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".finished"}, finished, 1);
    chk({tag, ".cycles"}, ncyc, exp_cycles);
    if (rst_at > 0) begin
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, ".no_pending"}, {busy, done}, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 0;
    foreach (mask[i]) mask[i] = '0;
    #1;
    chk_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle");

    mode = 0;
    run_sweep("good", 0, 0, NP);
    check_results("good");
    chk("good.pass_lit", pass, 1);

    mode = 1;
    run_sweep("zero", 0, 0, NP);
    check_results("zero");
    chk("zero.err_lit", err_count, 9);
    chk("zero.fa_lit", fail_a, 1);
    chk("zero.fb_lit", fail_b, 1);
`ifdef MULT_EVAL_HAMMING_EN
    chk("zero.ham_lit", ham_sum, 14);
`endif

    mode = 2;
    run_sweep("one", 0, 0, NP);
    check_results("one");
    chk("one.err_lit", err_count, 1);
    chk("one.fa_lit", fail_a, 3);
    chk("one.fb_lit", fail_b, 2);

    // start on cycle 5 is ignored, results still reflect the whole sweep
    mode = 1;
    run_sweep("restart5", 5, 0, NP);
    check_results("restart5");
    repeat (2) @(negedge clk);
    chk("restart5.stable", err_count, 9);

    mode = 0;
    run_sweep("from_done", 0, 0, NP);
    check_results("from_done");

    // start coincident with the last compare must not restart
    mode = 2;
    run_sweep("restart16", NP, 0, NP);
    repeat (2) @(negedge clk);
    check_results("restart16");

    // reset on cycle 8 of a failing sweep, then a clean rerun
    mode = 1;
    run_sweep("abort", 0, 8, 8);
    run_sweep("after_abort", 0, 0, NP);
    check_results("after_abort");

    mode = 3;
    for (int r = 0; r < 6; r++) begin
      foreach (mask[i])
        mask[i] = ($urandom_range(0, 2) == 0) ? (2*W)'($urandom) : '0;
      if (r == 5) foreach (mask[i]) mask[i] = '1;
      run_sweep($sformatf("rand%0d", r), 0, 0, NP);
      check_results($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multiplier_evaluator.md
MULTIPLIER_EVALUATOR -- requirements
Module: multiplier_evaluator

Interface
REQ-001 SHALL have parameter WIDTH, default 2, giving the operand width of the multiplier under test.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin an exhaustive sweep.
REQ-005 SHALL have ports A and B, output, WIDTH each, registered operands driven to the multiplier under test.
REQ-006 SHALL have port P, input, 2*WIDTH, the combinational product returned by the multiplier under test.
REQ-007 SHALL have port busy, output, 1, high while a sweep is running.
REQ-008 SHALL have port done, output, 1, high from sweep end until the next start or reset.
REQ-009 SHALL have port err_count, output, 2*WIDTH+1, the number of operand pairs with P != A*B.
REQ-010 SHALL have port pass, output, 1, meaning done and err_count==0.
REQ-011 SHALL have ports fail_a and fail_b, output, WIDTH each, holding the operands of the first mismatch.

Function
REQ-012 SHALL implement states IDLE, SWEEP and DONE.
REQ-013 IDLE/DONE + start -> SWEEP: clears idx, err_count, fail_a, fail_b, the first-fail flag and the Hamming sum.
REQ-014 SHALL hold a 2*WIDTH-bit index idx, with A=idx[WIDTH-1:0] and B=idx[2*WIDTH-1:WIDTH].
REQ-015 On each SWEEP edge, SHALL compare P with the exact 2*WIDTH-bit product A*B of the operands currently driven, with zero added latency.
REQ-016 On a mismatch, SHALL increment err_count; on the first mismatch only, SHALL capture A and B into fail_a and fail_b.
REQ-017 SHALL cover all 2^(2*WIDTH) pairs in exactly 2^(2*WIDTH) SWEEP cycles; at idx = all-ones, SHALL compare and then go to DONE without wrapping idx.
REQ-018 start while busy SHALL be ignored; start and the final compare in the same cycle SHALL not restart the sweep.
REQ-019 busy SHALL equal (state==SWEEP); done SHALL equal (state==DONE).
REQ-020 In IDLE and DONE, A and B SHALL hold their last values; results SHALL stay stable in DONE.
REQ-021 err_count SHALL never saturate; its width covers every pair failing.

Reset
REQ-022 rst SHALL force IDLE, idx=0, A=0, B=0, err_count=0, fail_a=0, fail_b=0, busy=0, done=0 and pass=0 immediately.
REQ-023 rst asserted mid-sweep SHALL abort the sweep, discard partial results and leave no pending start.

Configuration
REQ-024 With macro MULT_EVAL_HAMMING_EN defined, SHALL add output ham_sum, 2*WIDTH+$clog2(2*WIDTH)+1 bits wide.
REQ-025 ham_sum SHALL accumulate popcount(P ^ (A*B)) each SWEEP cycle, and SHALL be cleared by start and by reset.
REQ-026 Without MULT_EVAL_HAMMING_EN, the ham_sum port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-027 Package multiplier_eval_pkg SHALL hold the state enum and the width-derivation functions for the err_count and ham_sum widths.
REQ-028 Popcount SHALL be a sub-module eval_popcount, instantiated only under MULT_EVAL_HAMMING_EN.
REQ-029 The golden product SHALL be computed inline; no other sub-modules.

Verification (WIDTH=2, evaluator wired to a reference multiplier unless stated)
REQ-030 Correct multiplier, pulse start:
- busy is high for exactly 16 cycles, then done=1 and pass=1 with err_count=0.
REQ-031 P tied to 0:
- err_count=9, fail_a=1, fail_b=1, pass=0.
- With MULT_EVAL_HAMMING_EN: ham_sum=14.
REQ-032 P forced to A*B+1 only for A=3,B=2:
- err_count=1, fail_a=3, fail_b=2.
REQ-033 Pulse start again on cycle 5 of a sweep:
- The pulse is ignored and done still rises after cycle 16.
- Then start from DONE with a correct multiplier clears results and gives pass=1.
REQ-034 Assert rst on cycle 8 of a failing sweep:
- All outputs read 0 in the same cycle.
- A new start yields the full, uncorrupted result.
